// File: rtl/pkt_hdr_capture_pkg.sv
// Shared types and helpers for the packet header capture ingress stage.
package pkt_hdr_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } hdr_state_e;

    // FIFO entry layout is {tlast, tuser, tkeep, tdata}.
    function automatic int fifo_entry_w(input int data_w, input int user_w);
        return 1 + user_w + data_w / 8 + data_w;
    endfunction

endpackage

// File: rtl/pkt_hdr_capture_if.sv
// AXI-Stream beat bundle shared by the ingress and pass-through sides.
interface pkt_hdr_capture_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/pkt_hdr_capture_axis_beat_fifo.sv
// Synchronous first-word-fall-through beat FIFO; pointers carry an extra wrap bit.
module axis_beat_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_data = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en && !full)
            wptr_d = wptr_q + 1'b1;
        if (rd_en && !empty)
            rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pkt_hdr_capture.sv
// Captures the leading beats of each packet into a flat header vector and
// forwards every beat unchanged through a FWFT beat FIFO.
module pkt_hdr_capture
    import pkt_hdr_capture_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_HDR_BEATS          = 5,
    parameter int C_FIFO_DEPTH         = 32
) (
    input  logic                                    axis_clk,
    input  logic                                    areset,
    pkt_hdr_capture_if.slave                        s_axis,
    pkt_hdr_capture_if.master                       m_axis,
    output logic [C_HDR_BEATS*C_S_AXIS_DATA_WIDTH-1:0] hdr_data,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]         hdr_tuser,
    output logic [3:0]                              hdr_beats,
    output logic                                    hdr_valid,
    input  logic                                    hdr_ready,
    output logic [31:0]                             hdr_pkt_cnt
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int HB = C_HDR_BEATS;
    localparam int EW = fifo_entry_w(DW, UW);
    localparam int IW = (HB > 1) ? $clog2(HB) : 1;

    hdr_state_e              state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [HB-1:0][DW-1:0]   hdr_data_q, hdr_data_d;
    logic [UW-1:0]           hdr_tuser_q, hdr_tuser_d;
    logic [3:0]              hdr_beats_q, hdr_beats_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [31:0]             cnt_q, cnt_d;

    logic                    beat_acc;
    logic                    done;
    logic [3:0]              done_beats;
    logic                    fifo_full, fifo_empty;
    logic [EW-1:0]           fifo_wdata, fifo_rdata;

    // Only beat 0 waits on the consumer; it would overwrite a held header.
    assign s_axis.tready = !fifo_full && !(state_q == ST_IDLE && hdr_valid_q && !hdr_ready);
    assign beat_acc      = s_axis.tvalid && s_axis.tready;

    assign fifo_wdata = {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};

    axis_beat_fifo #(
        .DATA_W (EW),
        .DEPTH  (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (axis_clk),
        .rst     (areset),
        .wr_en   (beat_acc),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .rd_en   (m_axis.tready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = fifo_rdata;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hdr_data_d  = hdr_data_q;
        hdr_tuser_d = hdr_tuser_q;
        hdr_beats_d = hdr_beats_q;
        hdr_valid_d = hdr_valid_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        done_beats  = '0;

        if (hdr_valid_q && hdr_ready)
            hdr_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (beat_acc) begin
                    hdr_data_d    = '0;
                    hdr_data_d[0] = s_axis.tdata;
                    hdr_tuser_d   = s_axis.tuser;
                    idx_d         = 4'd1;
                    if (s_axis.tlast || HB == 1) begin
                        done       = 1'b1;
                        done_beats = 4'd1;
                        state_d    = s_axis.tlast ? ST_IDLE : ST_BODY;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (beat_acc) begin
                    hdr_data_d[idx_q[IW-1:0]] = s_axis.tdata;
                    idx_d = idx_q + 4'd1;
                    if (s_axis.tlast) begin
                        done       = 1'b1;
                        done_beats = idx_q + 4'd1;
                        state_d    = ST_IDLE;
                    end else if (idx_q == 4'(HB - 1)) begin
                        done       = 1'b1;
                        done_beats = 4'(HB);
                        state_d    = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (beat_acc && s_axis.tlast)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            hdr_valid_d = 1'b1;
            hdr_beats_d = done_beats;
            cnt_d       = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hdr_data_q  <= '0;
            hdr_tuser_q <= '0;
            hdr_beats_q <= '0;
            hdr_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hdr_data_q  <= hdr_data_d;
            hdr_tuser_q <= hdr_tuser_d;
            hdr_beats_q <= hdr_beats_d;
            hdr_valid_q <= hdr_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hdr_data    = hdr_data_q;
    assign hdr_tuser   = hdr_tuser_q;
    assign hdr_beats   = hdr_beats_q;
    assign hdr_valid   = hdr_valid_q;
    assign hdr_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_pkt_hdr_capture.sv
// Scoreboard bench: beats and headers are predicted on acceptance, checked on output.
module tb_pkt_hdr_capture;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int HB = 5;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [HB-1:0][DW-1:0] data;
        logic [UW-1:0]         user;
        logic [3:0]            beats;
        logic [31:0]           cnt;
        logic [31:0]           done_cyc;
    } hdr_t;

    logic clk = 1'b0;
    logic areset;
    logic [HB*DW-1:0] hdr_data;
    logic [UW-1:0]    hdr_tuser;
    logic [3:0]       hdr_beats;
    logic             hdr_valid;
    logic             hdr_ready;
    logic [31:0]      hdr_pkt_cnt;

    pkt_hdr_capture_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    pkt_hdr_capture_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    pkt_hdr_capture #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .C_HDR_BEATS          (HB),
        .C_FIFO_DEPTH         (DEPTH)
    ) dut (
        .axis_clk    (clk),
        .areset      (areset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .hdr_data    (hdr_data),
        .hdr_tuser   (hdr_tuser),
        .hdr_beats   (hdr_beats),
        .hdr_valid   (hdr_valid),
        .hdr_ready   (hdr_ready),
        .hdr_pkt_cnt (hdr_pkt_cnt)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    int    exp_cnt = 0;
    beat_t beat_q[$];
    hdr_t  hdr_q[$];
    logic [HB-1:0][DW-1:0] m_slots;
    logic [UW-1:0]         m_tuser;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
        for (int i = 0; i < UW / 32; i++) b.user[i*32 +: 32] = $urandom;
        b.keep = KW'($urandom);
        b.last = last;
        return b;
    endfunction

    task automatic model_accept(input int b, input beat_t bt);
        hdr_t h;
        acc_cnt++;
        beat_q.push_back(bt);
        if (b == 0) begin
            m_slots = '0;
            m_tuser = bt.user;
        end
        if (b < HB) begin
            m_slots[b] = bt.data;
            if (bt.last || b == HB - 1) begin
                exp_cnt++;
                h.data = m_slots; h.user = m_tuser; h.beats = 4'(b + 1);
                h.cnt = 32'(exp_cnt); h.done_cyc = 32'(cyc);
                hdr_q.push_back(h);
            end
        end
    endtask

    task automatic drive_pkt(input int n, input bit use_b0, input beat_t b0,
                             output int first_cyc, output int last_cyc);
        beat_t bt;
        bit ok;
        first_cyc = -1;
        last_cyc = -1;
        for (int b = 0; b < n; b++) begin
            bt = (b == 0 && use_b0) ? b0 : rnd_beat(b == n - 1);
            s_if.tdata = bt.data; s_if.tkeep = bt.keep;
            s_if.tuser = bt.user; s_if.tlast = bt.last;
            s_if.tvalid = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 400; w++) begin
                @(negedge clk);
                if (s_if.tready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL drive_timeout beat %0d: tready=%0b, required 1", b, s_if.tready);
                s_if.tvalid = 1'b0;
                return;
            end
            if (b == 0) first_cyc = cyc;
            last_cyc = cyc;
            model_accept(b, bt);
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int w = 0; w < 600; w++) begin
            @(negedge clk);
            if (beat_q.size() == 0 && hdr_q.size() == 0 && !m_if.tvalid) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_timeout: beats left %0d headers left %0d, required 0 0",
                     beat_q.size(), hdr_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Beat monitor: every transferred m_axis beat must match the predicted order.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (!areset && m_if.tvalid && m_if.tready) begin
            vectors++;
            if (beat_q.size() == 0) begin
                miscompares++;
                $display("FAIL m_axis_unexpected: got data %h, required no beat", m_if.tdata[63:0]);
            end else begin
                e = beat_q.pop_front();
                if (m_if.tdata !== e.data || m_if.tkeep !== e.keep ||
                    m_if.tuser !== e.user || m_if.tlast !== e.last) begin
                    miscompares++;
                    $display("FAIL m_axis_beat: got data %h last %0b keep %h, required data %h last %0b keep %h",
                             m_if.tdata[63:0], m_if.tlast, m_if.tkeep, e.data[63:0], e.last, e.keep);
                end
            end
        end
    end

    // Header monitor: latency on presentation, content on handshake.
    initial begin
        logic prev_v = 1'b0;
        logic prev_hs = 1'b0;
        hdr_t h;
        forever begin
            @(negedge clk);
            if (areset) begin
                prev_v = 1'b0; prev_hs = 1'b0;
            end else begin
                if (hdr_valid && (!prev_v || prev_hs)) begin
                    vectors++;
                    if (hdr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL hdr_unexpected: hdr_valid=1 cnt %0d, required no header", hdr_pkt_cnt);
                    end else if (32'(cyc) !== hdr_q[0].done_cyc + 32'd1) begin
                        miscompares++;
                        $display("FAIL hdr_latency: valid at cycle %0d, required %0d",
                                 cyc, hdr_q[0].done_cyc + 32'd1);
                    end
                end
                if (hdr_valid && hdr_ready && hdr_q.size() != 0) begin
                    h = hdr_q.pop_front();
                    vectors += 4;
                    if (hdr_data !== h.data) begin
                        miscompares++;
                        $display("FAIL hdr_data: got %h, required %h", hdr_data, h.data);
                    end
                    if (hdr_tuser !== h.user) begin
                        miscompares++;
                        $display("FAIL hdr_tuser: got %h, required %h", hdr_tuser, h.user);
                    end
                    if (hdr_beats !== h.beats) begin
                        miscompares++;
                        $display("FAIL hdr_beats: got %0d, required %0d", hdr_beats, h.beats);
                    end
                    if (hdr_pkt_cnt !== h.cnt) begin
                        miscompares++;
                        $display("FAIL hdr_pkt_cnt: got %0d, required %0d", hdr_pkt_cnt, h.cnt);
                    end
                end
                prev_v = hdr_valid;
                prev_hs = hdr_valid && hdr_ready;
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        vectors += 6;
        if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hdr_valid: got %0b, required 0", hdr_valid); end
        if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %0b, required 0", m_if.tvalid); end
        if (hdr_pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d, required 0", hdr_pkt_cnt); end
        if (hdr_data !== '0) begin miscompares++; $display("FAIL reset_hdr_data: got nonzero, required 0"); end
        if (hdr_beats !== 4'd0 || hdr_tuser !== '0) begin
            miscompares++; $display("FAIL reset_beats_tuser: got beats %0d, required 0", hdr_beats);
        end
        if (s_if.tready !== 1'b1) begin miscompares++; $display("FAIL reset_tready: got %0b, required 1", s_if.tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_long_pkt();
        int f, l;
        hdr_ready = 1'b1; m_if.tready = 1'b1;
        drive_pkt(7, 1'b0, '0, f, l);
        wait_drain();
        vectors++;
        if (hdr_pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL long_cnt: got %0d, required 1", hdr_pkt_cnt); end
    endtask

    task automatic test_short_after_long();
        int f, l;
        drive_pkt(5, 1'b0, '0, f, l);
        drive_pkt(2, 1'b0, '0, f, l);
        wait_drain();
        vectors += 2;
        if (hdr_data[HB*DW-1:2*DW] !== '0) begin
            miscompares++; $display("FAIL short_slots_zero: got %h, required 0", hdr_data[HB*DW-1:2*DW]);
        end
        if (hdr_beats !== 4'd2) begin miscompares++; $display("FAIL short_beats: got %0d, required 2", hdr_beats); end
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2;
        drive_pkt(1, 1'b0, '0, f1, l1);
        drive_pkt(1, 1'b0, '0, f2, l2);
        vectors++;
        if (f2 != l1 + 1) begin miscompares++; $display("FAIL b2b_bubble: second accept cycle %0d, required %0d", f2, l1 + 1); end
        wait_drain();
    endtask

    task automatic test_hold();
        int f, l, raise;
        logic [DW-1:0] a_data;
        beat_t b;
        hdr_ready = 1'b0;
        drive_pkt(1, 1'b0, '0, f, l);
        a_data = m_slots[0];
        repeat (2) begin @(posedge clk); #1; end
        b = rnd_beat(1'b1);
        s_if.tdata = b.data; s_if.tkeep = b.keep; s_if.tuser = b.user; s_if.tlast = b.last;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (s_if.tready !== 1'b0) begin miscompares++; $display("FAIL hold_tready: got %0b, required 0", s_if.tready); end
        if (hdr_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid: got %0b, required 1", hdr_valid); end
        if (hdr_data[DW-1:0] !== a_data) begin
            miscompares++; $display("FAIL hold_data: got %h, required %h", hdr_data[63:0], a_data[63:0]);
        end
        @(posedge clk); #1;
        raise = cyc;
        hdr_ready = 1'b1;
        drive_pkt(1, 1'b1, b, f, l);
        vectors++;
        if (f != raise) begin miscompares++; $display("FAIL hold_release: accepted at %0d, required %0d", f, raise); end
        wait_drain();
    endtask

    task automatic test_fifo_full();
        int base, f, l;
        m_if.tready = 1'b0; hdr_ready = 1'b1;
        base = acc_cnt;
        fork
            drive_pkt(40, 1'b0, '0, f, l);
            begin
                repeat (50) @(negedge clk);
                vectors += 3;
                if (acc_cnt - base != DEPTH) begin
                    miscompares++; $display("FAIL full_accepted: got %0d, required %0d", acc_cnt - base, DEPTH);
                end
                if (s_if.tready !== 1'b0) begin miscompares++; $display("FAIL full_tready: got %0b, required 0", s_if.tready); end
                if (m_if.tvalid !== 1'b1) begin miscompares++; $display("FAIL full_m_tvalid: got %0b, required 1", m_if.tvalid); end
                @(posedge clk); #1;
                m_if.tready = 1'b1;
            end
        join
        wait_drain();
        vectors++;
        if (acc_cnt - base != 40) begin miscompares++; $display("FAIL full_total: got %0d, required 40", acc_cnt - base); end
    endtask

    task automatic test_reset_mid();
        int f, l;
        beat_t b;
        m_if.tready = 1'b0; hdr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = rnd_beat(1'b0);
            s_if.tdata = b.data; s_if.tkeep = b.keep; s_if.tuser = b.user; s_if.tlast = 1'b0;
            s_if.tvalid = 1'b1;
            if (i == 2) areset = 1'b1;
            @(negedge clk);
            if (i < 2) begin
                vectors++;
                if (s_if.tready !== 1'b1) begin miscompares++; $display("FAIL midrst_tready: got %0b, required 1", s_if.tready); end
            end
            @(posedge clk); #1;
        end
        areset = 1'b0; s_if.tvalid = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        vectors += 4;
        if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %0b, required 0", hdr_valid); end
        if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_m_tvalid: got %0b, required 0", m_if.tvalid); end
        if (hdr_pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL midrst_cnt: got %0d, required 0", hdr_pkt_cnt); end
        if (hdr_data !== '0) begin miscompares++; $display("FAIL midrst_data: got nonzero, required 0"); end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        drive_pkt(3, 1'b0, '0, f, l);
        wait_drain();
        vectors++;
        if (hdr_pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL midrst_next_cnt: got %0d, required 1", hdr_pkt_cnt); end
    endtask

    initial begin
        areset = 1'b1; hdr_ready = 1'b0; m_if.tready = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        test_reset();
        test_long_pkt();
        test_short_after_long();
        test_back_to_back();
        test_hold();
        test_fifo_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
